regfile_wb_arbiter: RTL and testbench

Write-back arbiter and ordering queue in front of the 32×32 register file's single write port. Merges ALU-result and memory-load write-back streams into one in-order write per cycle. Also publishes a per-register pending mask so issue logic can stall reads of registers with queued writes. Sits between the execute/memory stages and the register file write port (write enable, write address, write data).

---
 rtl/regfile_wb_arbiter_if.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the write-back request streams, the flush strobe and the register
// file write port of the write-back arbiter.
//   master : execute/memory side (drives requests and flush, sees readies,
//            register file write and pending mask)
//   slave  : the arbiter itself
// Signals:
//   mem_valid/mem_ready/mem_addr/mem_data  load write-back handshake
//   alu_valid/alu_ready/alu_addr/alu_data  ALU write-back handshake
//   flush                                   discard all queued writes
//   rf_we/rf_waddr/rf_wdata                 register file write port
//   pending                                 per-register queued-write mask
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic                   mem_valid;
   logic                   mem_ready;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_data;
   logic                   alu_valid;
   logic                   alu_ready;
   logic [ADDR_W-1:0]      alu_addr;
   logic [DATA_W-1:0]      alu_data;
   logic                   flush;
   logic                   rf_we;
   logic [ADDR_W-1:0]      rf_waddr;
   logic [DATA_W-1:0]      rf_wdata;
   logic [2**ADDR_W-1:0]   pending;

   modport master (
      output mem_valid, mem_addr, mem_data,
      output alu_valid, alu_addr, alu_data,
      output flush,
      input  mem_ready, alu_ready,
      input  rf_we, rf_waddr, rf_wdata, pending
   );

   modport slave (
      input  mem_valid, mem_addr, mem_data,
      input  alu_valid, alu_addr, alu_data,
      input  flush,
      output mem_ready, alu_ready,
      output rf_we, rf_waddr, rf_wdata, pending
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Merges the load and ALU write-back streams into one in-order write per
// cycle for the single register file write port, and publishes a mask of
// registers that still have writes queued so issue can stall on them.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    regfile_wb_arbiter_if.slave (requests, flush, rf write, pending)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NREG  = 2**ADDR_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // Entry storage is not reset: only slots covered by count are ever read.
   logic [ADDR_W-1:0] entry_addr_q [DEPTH];
   logic [DATA_W-1:0] entry_data_q [DEPTH];

   logic              mem_ready, alu_ready;
   logic              mem_push, alu_push, pop;
   logic              wr0_en, wr1_en;
   logic [ADDR_W-1:0] wr0_addr;
   logic [DATA_W-1:0] wr0_data;
   logic [PTR_W-1:0]  tail_p1;
   logic [1:0]        n_push;
   logic [PTR_W-1:0]  slot_off;
   logic [NREG-1:0]   pending_v;

   always_comb begin
      // Readies come from registered count only, so a pop in this cycle
      // never frees space for a push in the same cycle.
      mem_ready = (count_q < DEPTH_C);
      alu_ready = (count_q < (DEPTH_C - CNT_W'(1)));

      // Writes to r0 complete the handshake but are never queued; a flush
      // drops anything arriving in the same cycle.
      mem_push  = bus.mem_valid && mem_ready && (bus.mem_addr != '0) && !bus.flush;
      alu_push  = bus.alu_valid && alu_ready && (bus.alu_addr != '0) && !bus.flush;
      pop       = (count_q != '0);

      // The load is the older instruction, so it takes the first slot; the
      // ALU entry slides into the first slot when the load is not queued.
      wr0_en    = mem_push || alu_push;
      wr1_en    = mem_push && alu_push;
      wr0_addr  = mem_push ? bus.mem_addr : bus.alu_addr;
      wr0_data  = mem_push ? bus.mem_data : bus.alu_data;
      tail_p1   = tail_q + PTR_W'(1);
      n_push    = {1'b0, mem_push} + {1'b0, alu_push};

      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PTR_W'(pop);
         tail_d  = tail_q + PTR_W'(n_push);
         count_d = count_q + CNT_W'(n_push) - CNT_W'(pop);
      end

      // An entry is occupied when its distance from head is below count;
      // the head being written this cycle still counts as pending.
      pending_v = '0;
      slot_off  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_off = PTR_W'(i) - head_q;
         if ({1'b0, slot_off} < count_q) begin
            pending_v[entry_addr_q[i]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr0_en) begin
         entry_addr_q[tail_q] <= wr0_addr;
         entry_data_q[tail_q] <= wr0_data;
      end
      if (wr1_en) begin
         entry_addr_q[tail_p1] <= bus.alu_addr;
         entry_data_q[tail_p1] <= bus.alu_data;
      end
   end

   // Write port is driven straight from the head slot; forced to zero when
   // empty so stale storage never shows on the bus.
   assign bus.mem_ready = mem_ready;
   assign bus.alu_ready = alu_ready;
   assign bus.rf_we     = pop;
   assign bus.rf_waddr  = pop ? entry_addr_q[head_q] : '0;
   assign bus.rf_wdata  = pop ? entry_data_q[head_q] : '0;
   assign bus.pending   = pending_v;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t q[$];            // reference queue of writes still to be issued
   int   checks = 0;
   int   errors = 0;
   bit   mem_acc, alu_acc; // handshake completed at the last edge

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input bit mv, input int ma, input logic [31:0] md,
                         input bit av, input int aa, input logic [31:0] ad, input bit fl);
      bus.mem_valid = mv;
      bus.mem_addr  = ADDR_W'(ma);
      bus.mem_data  = md;
      bus.alu_valid = av;
      bus.alu_addr  = ADDR_W'(aa);
      bus.alu_data  = ad;
      bus.flush     = fl;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Compare every output against what the reference queue implies.
   task automatic check_outputs(input string ph);
      logic [31:0] pend;
      pend = '0;
      foreach (q[i]) pend[q[i].a] = 1'b1;
      chk({ph, "_rf_we"},     bus.rf_we,    q.size() != 0);
      chk({ph, "_rf_waddr"},  bus.rf_waddr, q.size() != 0 ? q[0].a : '0);
      chk({ph, "_rf_wdata"},  bus.rf_wdata, q.size() != 0 ? q[0].d : '0);
      chk({ph, "_pending"},   bus.pending,  pend);
      chk({ph, "_mem_ready"}, bus.mem_ready, DEPTH - q.size() >= 1);
      chk({ph, "_alu_ready"}, bus.alu_ready, DEPTH - q.size() >= 2);
   endtask

   // One clock cycle: check outputs, advance the model, cross the edge.
   task automatic step(input string ph);
      int  sz;
      ent_t e;
      #1;
      check_outputs(ph);
      sz      = q.size();
      mem_acc = bus.mem_valid && (DEPTH - sz >= 1);
      alu_acc = bus.alu_valid && (DEPTH - sz >= 2);
      if (sz != 0) void'(q.pop_front());
      if (bus.flush) begin
         q.delete();
      end else begin
         if (mem_acc && bus.mem_addr != 0) begin
            e.a = bus.mem_addr; e.d = bus.mem_data; q.push_back(e);
         end
         if (alu_acc && bus.alu_addr != 0) begin
            e.a = bus.alu_addr; e.d = bus.alu_data; q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single ALU write r5
      set_in(0, 0, 0, 1, 5, 32'h1234, 0);
      step("t1a");
      idle();
      chk("t1_we", bus.rf_we, 1);
      chk("t1_waddr", bus.rf_waddr, 5);
      chk("t1_wdata", bus.rf_wdata, 32'h1234);
      chk("t1_pend5", bus.pending[5], 1);
      step("t1b");
      chk("t1_empty_we", bus.rf_we, 0);
      chk("t1_empty_pend", bus.pending, 0);

      // Simultaneous pair to r3: load first, ALU second
      set_in(1, 3, 32'hAAAA, 1, 3, 32'hBBBB, 0);
      step("t2a");
      idle();
      chk("t2_first", bus.rf_wdata, 32'hAAAA);
      chk("t2_pend3a", bus.pending[3], 1);
      step("t2b");
      chk("t2_second", bus.rf_wdata, 32'hBBBB);
      chk("t2_pend3b", bus.pending[3], 1);
      step("t2c");
      chk("t2_done", bus.rf_we, 0);

      // Fill: both streams valid every cycle, senders hold until accepted
      set_in(1, 1, 32'h100, 1, 2, 32'h200, 0);
      for (int i = 0; i < 12; i++) begin
         step("fill");
         if (mem_acc) begin
            bus.mem_addr = ADDR_W'($urandom_range(1, 31));
            bus.mem_data = $urandom;
         end
         if (alu_acc) begin
            bus.alu_addr = ADDR_W'($urandom_range(1, 31));
            bus.alu_data = $urandom;
         end
         if (i >= 2) chk("fill_we", bus.rf_we, 1);
      end
      idle();
      repeat (5) step("drain");

      // Address 0 on the load side: only r7 queued
      set_in(1, 0, 32'hFFFF, 1, 7, 32'h7, 0);
      step("t4a");
      idle();
      chk("t4_waddr", bus.rf_waddr, 7);
      chk("t4_wdata", bus.rf_wdata, 32'h7);
      chk("t4_pend0", bus.pending[0], 0);
      step("t4b");
      chk("t4_done", bus.rf_we, 0);

      // Flush with 3 entries queued and a push in the flush cycle
      set_in(1, 1, 32'h11, 1, 2, 32'h22, 0);
      step("t5a");
      set_in(1, 4, 32'h44, 1, 6, 32'h66, 0);
      step("t5b");
      chk("t5_count3_alu_ready", bus.alu_ready, 0);
      set_in(0, 0, 0, 0, 0, 0, 1);
      bus.mem_valid = 1; bus.mem_addr = 9; bus.mem_data = 32'h99;
      chk("t5_flush_we", bus.rf_we, 1);
      step("t5c");
      idle();
      chk("t5_post_we", bus.rf_we, 0);
      chk("t5_post_pend", bus.pending, 0);
      step("t5d");

      // Asynchronous reset with two entries queued
      set_in(1, 10, 32'hA0, 1, 11, 32'hB0, 0);
      step("t6a");
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("t6_we", bus.rf_we, 0);
      chk("t6_mem_ready", bus.mem_ready, 1);
      chk("t6_alu_ready", bus.alu_ready, 1);
      chk("t6_pend", bus.pending, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) step("t6_after");

      // Randomized traffic against the reference queue
      mem_acc = 1; alu_acc = 1;
      for (int i = 0; i < 400; i++) begin
         if (!bus.mem_valid || mem_acc) begin
            bus.mem_valid = ($urandom_range(0, 99) < 60);
            bus.mem_addr  = ADDR_W'($urandom_range(0, 31));
            bus.mem_data  = $urandom;
         end
         if (!bus.alu_valid || alu_acc) begin
            bus.alu_valid = ($urandom_range(0, 99) < 60);
            bus.alu_addr  = ADDR_W'($urandom_range(0, 31));
            bus.alu_data  = $urandom;
         end
         bus.flush = ($urandom_range(0, 39) == 0);
         step("rand");
      end
      idle();
      repeat (6) step("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
